sd_bus_sched: RTL and testbench

// - Owns the SPI-mode SD bus (SD_cs, SD_datain) and sequences its users: the initializer first,

---
 rtl/sd_pkg.sv | 19 +
 rtl/sd_rr_arb2.sv | 19 +
 rtl/sd_bus_sched.sv | 153 +++++++++++++++
 tb/tb_sd_bus_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared encodings for the SD bus scheduler
package sd_pkg;
   localparam int SD_SEC_W = 32;

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_GAP  = 3'd1;
   localparam logic [2:0] S_IDLE = 3'd2;
   localparam logic [2:0] S_RD   = 3'd3;
   localparam logic [2:0] S_WR   = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_INIT = 2'd1;
   localparam logic [1:0] OWN_RD   = 2'd2;
   localparam logic [1:0] OWN_WR   = 2'd3;

   localparam logic LAST_RD = 1'b0;
   localparam logic LAST_WR = 1'b1;
endpackage

// File: rtl/sd_rr_arb2.sv
// rtl/sd_rr_arb2.sv - two-way round-robin arbiter, bit0 = read, bit1 = write
module sd_rr_arb2
   import sd_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);
   // On a tie the engine that did not go last wins.
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = (i_last == LAST_WR) ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end
endmodule

// File: rtl/sd_bus_sched.sv
// rtl/sd_bus_sched.sv - SPI-mode SD bus owner: init, then round-robin read/write engines
module sd_bus_sched
   import sd_pkg::*;
#(
   parameter int GAP_CLKS = 8,
   parameter int TIMEOUT  = 65535
)
(
   input  logic                SD_clk,
   input  logic                rst_n,
   input  logic                init_cs,
   input  logic                init_datain,
   input  logic                init_o,
   input  logic                rd_req,
   input  logic [SD_SEC_W-1:0] rd_sec,
   input  logic                rd_cs,
   input  logic                rd_datain,
   input  logic                rd_done,
   input  logic                wr_req,
   input  logic [SD_SEC_W-1:0] wr_sec,
   input  logic                wr_cs,
   input  logic                wr_datain,
   input  logic                wr_done,
   input  logic                clr_err,
   output logic                SD_cs,
   output logic                SD_datain,
   output logic [SD_SEC_W-1:0] sd_sec,
   output logic                rd_start,
   output logic                wr_start,
   output logic                rd_ack,
   output logic                wr_ack,
   output logic                busy,
   output logic                err
);
   localparam logic [3:0]  GAP_LAST = 4'(GAP_CLKS - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   logic [2:0]          r_state;
   logic [1:0]          r_owner;
   logic                r_last;
   logic [3:0]          r_gap;
   logic [15:0]         r_to;
   logic [SD_SEC_W-1:0] r_sec;
   logic                r_rd_start, r_wr_start, r_rd_ack, r_wr_ack, r_err;
   logic [1:0]          w_gnt;
   logic                w_done;

   sd_rr_arb2 u_arb (
      .i_req  ({wr_req, rd_req}),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   // Pins follow the registered owner with no extra pipeline stage.
   always_comb begin
      SD_cs     = 1'b1;
      SD_datain = 1'b1;
      case (r_owner)
         OWN_INIT: begin SD_cs = init_cs; SD_datain = init_datain; end
         OWN_RD:   begin SD_cs = rd_cs;   SD_datain = rd_datain;   end
         OWN_WR:   begin SD_cs = wr_cs;   SD_datain = wr_datain;   end
         default:  begin SD_cs = 1'b1;    SD_datain = 1'b1;        end
      endcase
   end

   assign w_done   = (r_state == S_RD) ? rd_done : wr_done;
   assign sd_sec   = r_sec;
   assign rd_start = r_rd_start;
   assign wr_start = r_wr_start;
   assign rd_ack   = r_rd_ack;
   assign wr_ack   = r_wr_ack;
   assign err      = r_err;
   assign busy     = (r_state != S_IDLE);

   always_ff @(posedge SD_clk) begin
      if (!rst_n) begin
         r_state    <= S_INIT;
         r_owner    <= OWN_INIT;
         r_last     <= LAST_WR;
         r_gap      <= '0;
         r_to       <= '0;
         r_sec      <= '0;
         r_rd_start <= 1'b0;
         r_wr_start <= 1'b0;
         r_rd_ack   <= 1'b0;
         r_wr_ack   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_rd_start <= 1'b0;
         r_wr_start <= 1'b0;
         r_rd_ack   <= 1'b0;
         r_wr_ack   <= 1'b0;
         case (r_state)
            S_INIT: begin
               if (init_o) begin
                  r_state <= S_GAP;
                  r_owner <= OWN_NONE;
                  r_gap   <= '0;
               end
            end
            S_GAP: begin
               if (r_gap == GAP_LAST) r_state <= S_IDLE;
               else                   r_gap   <= r_gap + 4'd1;
            end
            S_IDLE: begin
               if (w_gnt[0]) begin
                  r_sec      <= rd_sec;
                  r_owner    <= OWN_RD;
                  r_rd_start <= 1'b1;
                  r_last     <= LAST_RD;
                  r_to       <= '0;
                  r_state    <= S_RD;
               end else if (w_gnt[1]) begin
                  r_sec      <= wr_sec;
                  r_owner    <= OWN_WR;
                  r_wr_start <= 1'b1;
                  r_last     <= LAST_WR;
                  r_to       <= '0;
                  r_state    <= S_WR;
               end
            end
            S_RD, S_WR: begin
               // Completion beats expiry when both land on the same cycle.
               if (w_done) begin
                  r_rd_ack <= (r_state == S_RD);
                  r_wr_ack <= (r_state == S_WR);
                  r_owner  <= OWN_NONE;
                  r_gap    <= '0;
                  r_state  <= S_GAP;
               end else if (r_to == TO_LAST) begin
                  r_err   <= 1'b1;
                  r_owner <= OWN_NONE;
                  r_state <= S_ERR;
               end else begin
                  r_to <= r_to + 16'd1;
               end
            end
            S_ERR: begin
               if (clr_err) begin
                  r_err   <= 1'b0;
                  r_gap   <= '0;
                  r_state <= S_GAP;
               end
            end
            default: begin
               r_owner <= OWN_NONE;
               r_gap   <= '0;
               r_state <= S_GAP;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sd_bus_sched.sv
// tb/tb_sd_bus_sched.sv - randomized directed bench for sd_bus_sched against a transaction-level model
module tb_sd_bus_sched;
   localparam int GAP = 8;
   localparam int TMO = 100;

   logic        SD_clk = 1'b0;
   logic        rst_n, init_cs, init_datain, init_o;
   logic        rd_req, rd_cs, rd_datain, rd_done;
   logic        wr_req, wr_cs, wr_datain, wr_done, clr_err;
   logic [31:0] rd_sec, wr_sec;
   logic        SD_cs, SD_datain, rd_start, wr_start, rd_ack, wr_ack, busy, err;
   logic [31:0] sd_sec;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          m_last = 1;   // 0 = read went last, 1 = write went last
   int          m_own  = 1;   // 0 none, 1 init, 2 read, 3 write
   logic [31:0] m_sec  = '0;
   int          g;

   always #5 SD_clk = ~SD_clk;

   sd_bus_sched #(.GAP_CLKS(GAP), .TIMEOUT(TMO)) dut (
      .SD_clk(SD_clk), .rst_n(rst_n), .init_cs(init_cs), .init_datain(init_datain),
      .init_o(init_o), .rd_req(rd_req), .rd_sec(rd_sec), .rd_cs(rd_cs),
      .rd_datain(rd_datain), .rd_done(rd_done), .wr_req(wr_req), .wr_sec(wr_sec),
      .wr_cs(wr_cs), .wr_datain(wr_datain), .wr_done(wr_done), .clr_err(clr_err),
      .SD_cs(SD_cs), .SD_datain(SD_datain), .sd_sec(sd_sec), .rd_start(rd_start),
      .wr_start(wr_start), .rd_ack(rd_ack), .wr_ack(wr_ack), .busy(busy), .err(err)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge SD_clk);
      #1;
   endtask

   task automatic rand_pins();
      init_cs = 1'($urandom); init_datain = 1'($urandom);
      rd_cs   = 1'($urandom); rd_datain   = 1'($urandom);
      wr_cs   = 1'($urandom); wr_datain   = 1'($urandom);
   endtask

   task automatic chk_pins(input string tag);
      logic ecs, edi;
      case (m_own)
         1:       begin ecs = init_cs; edi = init_datain; end
         2:       begin ecs = rd_cs;   edi = rd_datain;   end
         3:       begin ecs = wr_cs;   edi = wr_datain;   end
         default: begin ecs = 1'b1;    edi = 1'b1;        end
      endcase
      chk1({tag, "_cs"}, SD_cs, ecs);
      chk1({tag, "_di"}, SD_datain, edi);
   endtask

   // Called just after the edge that entered the gap; leaves the bench one edge into idle.
   task automatic check_gap();
      m_own = 0;
      for (int i = 0; i < GAP; i++) begin
         if (i > 0) tick();
         rand_pins();
         rd_req = 1'($urandom);
         wr_req = 1'($urandom);
         #1;
         chk_pins("gap");
         chk1("gap_busy", busy, 1'b1);
         chk1("gap_rd_start", rd_start, 1'b0);
         chk1("gap_wr_start", wr_start, 1'b0);
      end
      tick();
      rd_req = 1'b0;
      wr_req = 1'b0;
      rand_pins();
      #1;
      chk1("idle_busy", busy, 1'b0);
      chk_pins("idle");
   endtask

   task automatic grant(input int mask, input logic [31:0] rs, input logic [31:0] ws, output int gg);
      rd_sec = rs;
      wr_sec = ws;
      rd_req = (mask == 1 || mask == 3);
      wr_req = (mask == 2 || mask == 3);
      if (mask == 3) gg = (m_last == 1) ? 2 : 3;
      else           gg = (mask == 1) ? 2 : 3;
      m_last = (gg == 2) ? 0 : 1;
      m_sec  = (gg == 2) ? rs : ws;
      tick();
      m_own = gg;
      chk1("rd_start", rd_start, gg == 2);
      chk1("wr_start", wr_start, gg == 3);
      chk32("sd_sec", sd_sec, m_sec);
      chk1("grant_busy", busy, 1'b1);
   endtask

   // Runs dly cycles of ownership; with fin the owner's done lands on cycle dly.
   task automatic run(input int gg, input int dly, input bit fin);
      for (int k = 1; k <= dly; k++) begin
         if (k > 1) tick();
         rand_pins();
         if (gg == 2) begin rd_done = fin && (k == dly); wr_done = 1'($urandom); end
         else         begin wr_done = fin && (k == dly); rd_done = 1'($urandom); end
         #1;
         chk_pins("xfer");
         chk1("xfer_err", err, 1'b0);
         if (k > 1) chk1("xfer_start", rd_start | wr_start, 1'b0);
      end
      tick();
      rd_done = 1'b0;
      wr_done = 1'b0;
      m_own = 0;
      if (fin) begin
         chk1("rd_ack", rd_ack, gg == 2);
         chk1("wr_ack", wr_ack, gg == 3);
         chk1("ack_err", err, 1'b0);
         if (gg == 2) rd_req = 1'b0; else wr_req = 1'b0;
         check_gap();
      end else begin
         chk1("tmo_err", err, 1'b1);
         chk1("tmo_rd_ack", rd_ack, 1'b0);
         chk1("tmo_wr_ack", wr_ack, 1'b0);
         chk_pins("tmo");
      end
   endtask

   initial begin
      rst_n = 1'b0; init_o = 1'b0; clr_err = 1'b0;
      rd_req = 1'b0; wr_req = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
      rd_sec = '0; wr_sec = '0;
      rand_pins();
      tick();
      tick();
      chk1("rst_busy", busy, 1'b1);
      chk1("rst_err", err, 1'b0);
      chk32("rst_sec", sd_sec, 32'h0);
      chk1("rst_start", rd_start | wr_start, 1'b0);
      chk1("rst_ack", rd_ack | wr_ack, 1'b0);
      chk_pins("rst");
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         rand_pins();
         #1;
         chk_pins("init");
         chk1("init_busy", busy, 1'b1);
      end
      init_o = 1'b1;
      tick();
      init_o = 1'b0;
      check_gap();

      grant(1, 32'h0000_1234, $urandom, g);
      run(g, $urandom_range(1, 20), 1'b1);

      for (int t = 0; t < 4; t++) begin
         grant(3, $urandom, $urandom, g);
         run(g, $urandom_range(1, 12), 1'b1);
      end

      for (int t = 0; t < 6; t++) begin
         grant($urandom_range(1, 3), $urandom, $urandom, g);
         run(g, $urandom_range(1, 30), 1'b1);
      end

      grant(1, $urandom, $urandom, g);
      run(g, TMO, 1'b1);

      grant(2, $urandom, $urandom, g);
      run(g, TMO, 1'b0);
      wr_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         rd_req = 1'b1;
         wr_req = 1'($urandom);
         rand_pins();
         #1;
         chk1("err_rd_start", rd_start, 1'b0);
         chk1("err_busy", busy, 1'b1);
         chk1("err_hold", err, 1'b1);
         chk32("err_sec", sd_sec, m_sec);
         chk_pins("err");
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk1("clr_err", err, 1'b0);
      check_gap();
      grant(1, $urandom, $urandom, g);
      run(g, $urandom_range(1, 10), 1'b1);

      grant(2, $urandom, $urandom, g);
      for (int i = 0; i < 3; i++) begin
         tick();
         rand_pins();
      end
      rst_n = 1'b0;
      init_o = 1'b1;
      tick();
      rst_n = 1'b1;
      m_own = 1;
      m_last = 1;
      rand_pins();
      #1;
      chk_pins("midrst");
      chk32("midrst_sec", sd_sec, 32'h0);
      chk1("midrst_wr_ack", wr_ack, 1'b0);
      chk1("midrst_busy", busy, 1'b1);
      chk1("midrst_err", err, 1'b0);
      wr_req = 1'b0;
      tick();
      init_o = 1'b0;
      check_gap();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
